// File: rtl/vga_rst_seq_pkg.sv
// Shared definitions for the VGA reset sequencer: state encodings, widths and
// the saturating lock-loss counter increment.
package vga_rst_seq_pkg;

    localparam int STATE_W  = 3;
    localparam int RELOCK_W = 8;

    localparam logic [STATE_W-1:0] S_RESET     = 3'd0;
    localparam logic [STATE_W-1:0] S_WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] S_HOLD      = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] S_LOST      = 3'd4;

    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (v == {RELOCK_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_rst_seq_if.sv
// Signal bundle between the sequencer and its surroundings: async lock/enable
// inputs in, controller reset/enable and debug status out.
interface vga_rst_seq_if;
    import vga_rst_seq_pkg::*;

    logic                locked_in;
    logic                en_in;
    logic                sys_rst_out;
    logic                clk_en_out;
    logic [STATE_W-1:0]  state_out;
    logic [RELOCK_W-1:0] relock_cnt;
    logic                lock_timeout_out;

    modport slave (
        input  locked_in, en_in,
        output sys_rst_out, clk_en_out, state_out, relock_cnt, lock_timeout_out
    );

    modport master (
        output locked_in, en_in,
        input  sys_rst_out, clk_en_out, state_out, relock_cnt, lock_timeout_out
    );

endinterface

// File: rtl/vga_rst_seq_sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-low clear.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vga_rst_seq.sv
// Reset/enable sequencer for the VGA controller: qualifies MMCM lock, holds
// reset, then gates the clock enable. Optional lock timeout via LOCK_TIMEOUT_EN.
module vga_rst_seq
    import vga_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_STABLE    = 16,
    parameter int HOLD_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          vga_clk_in,
    input  logic          vga_rst_n,
    vga_rst_seq_if.slave  bus
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic                locked_s, en_s;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [SW-1:0]       stab_cnt_q, stab_cnt_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                sys_rst_q, sys_rst_d;
    logic                clk_en_q, clk_en_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk(vga_clk_in), .rst_n(vga_rst_n), .d(bus.locked_in), .q(locked_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk(vga_clk_in), .rst_n(vga_rst_n), .d(bus.en_in), .q(en_s));

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        relock_d   = relock_q;
        case (state_q)
            S_RESET: begin
                state_d    = S_WAIT_LOCK;
                stab_cnt_d = '0;
            end
            S_WAIT_LOCK: begin
                if (!locked_s) begin
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                    if (stab_cnt_q == SW'(LOCK_STABLE - 1)) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // A drop on the final hold edge still wins over promotion to RUN.
                if (!locked_s) begin
                    state_d    = S_WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_LOST;
                    relock_d = sat_inc(relock_q);
                end
            end
            S_LOST: begin
                state_d    = S_WAIT_LOCK;
                stab_cnt_d = '0;
            end
            default: state_d = S_RESET;
        endcase
        sys_rst_d = (state_d != S_RUN);
        clk_en_d  = (state_d == S_RUN) & en_s;
    end

    always_ff @(posedge vga_clk_in) begin
        if (!vga_rst_n) begin
            state_q    <= S_RESET;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            relock_q   <= '0;
            sys_rst_q  <= 1'b1;
            clk_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            relock_q   <= relock_d;
            sys_rst_q  <= sys_rst_d;
            clk_en_q   <= clk_en_d;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;

    // Counter saturates at the threshold so the flag can never be missed by a wrap.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d == S_WAIT_LOCK && state_q != S_WAIT_LOCK)
            to_cnt_d = '0;
        else if ((state_q == S_WAIT_LOCK || state_q == S_HOLD) &&
                 to_cnt_q != TW'(TIMEOUT_CYCLES))
            to_cnt_d = to_cnt_q + 1'b1;
        timeout_d = timeout_q | (to_cnt_d == TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge vga_clk_in) begin
        if (!vga_rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.lock_timeout_out = timeout_q;
`else
    assign bus.lock_timeout_out = 1'b0;
`endif

    assign bus.sys_rst_out = sys_rst_q;
    assign bus.clk_en_out  = clk_en_q;
    assign bus.state_out   = state_q;
    assign bus.relock_cnt  = relock_q;

endmodule

// File: tb/tb_vga_rst_seq.sv
// Directed bench for vga_rst_seq: expectations are queued when stimulus is
// driven and popped/compared after the corresponding clock edges.
module tb_vga_rst_seq;
    import vga_rst_seq_pkg::*;

    typedef struct {
        string          tag;
        logic [2:0]     st;
        logic           rst;
        logic           ce;
        logic [7:0]     rc;
        logic           to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    int   m_rc   = 0;
    logic m_to   = 1'b0;
    exp_t sbq[$];

    vga_rst_seq_if bus ();

`ifdef LOCK_TIMEOUT_EN
    vga_rst_seq #(.TIMEOUT_CYCLES(100)) dut (
`else
    vga_rst_seq dut (
`endif
        .vga_clk_in(clk),
        .vga_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic r, input logic ce);
        exp_t e;
        e.tag = tag; e.st = st; e.rst = r; e.ce = ce;
        e.rc = 8'(m_rc); e.to = m_to;
        sbq.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; fails++;
            $error("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        e = sbq.pop_front();
        checks++;
        assert (bus.state_out === e.st) else begin
            fails++; $error("FAIL %s state got %0d required %0d", e.tag, bus.state_out, e.st);
        end
        checks++;
        assert (bus.sys_rst_out === e.rst) else begin
            fails++; $error("FAIL %s sys_rst got %b required %b", e.tag, bus.sys_rst_out, e.rst);
        end
        checks++;
        assert (bus.clk_en_out === e.ce) else begin
            fails++; $error("FAIL %s clk_en got %b required %b", e.tag, bus.clk_en_out, e.ce);
        end
        checks++;
        assert (bus.relock_cnt === e.rc) else begin
            fails++; $error("FAIL %s relock got %0d required %0d", e.tag, bus.relock_cnt, e.rc);
        end
        checks++;
        assert (bus.lock_timeout_out === e.to) else begin
            fails++; $error("FAIL %s timeout got %b required %b", e.tag, bus.lock_timeout_out, e.to);
        end
    endtask

    // Drive lock high at edge 0 of WAIT_LOCK and expect release exactly at edge 81.
    task automatic qualify(input string tag);
        bus.locked_in = 1'b1;
        push({tag, "_pre"}, S_HOLD, 1'b1, 1'b0); step(81); chk();
        push({tag, "_rel"}, S_RUN, 1'b0, bus.en_in); step(1); chk();
    endtask

    // Drop lock in RUN: reset rises on edge 2, WAIT_LOCK one edge later.
    task automatic lose(input string tag);
        bus.locked_in = 1'b0;
        push({tag, "_e1"}, S_RUN, 1'b0, bus.en_in); step(2); chk();
        m_rc = (m_rc == 255) ? 255 : m_rc + 1;
        push({tag, "_e2"}, S_LOST, 1'b1, 1'b0); step(1); chk();
        push({tag, "_wt"}, S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();
    endtask

    initial begin
        rst_n = 1'b0; bus.locked_in = 1'b0; bus.en_in = 1'b0;
        push("reset", S_RESET, 1'b1, 1'b0); step(5); chk();
        rst_n = 1'b1;
        push("to_wait", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();

        bus.en_in = 1'b1;
        qualify("powerup");

        // en_in only moves clk_en_out, two edges after being sampled
        bus.en_in = 1'b0;
        push("en_lo_e1", S_RUN, 1'b0, 1'b1); step(2); chk();
        push("en_lo_e2", S_RUN, 1'b0, 1'b0); step(1); chk();
        bus.en_in = 1'b1;
        push("en_hi_e1", S_RUN, 1'b0, 1'b0); step(2); chk();
        push("en_hi_e2", S_RUN, 1'b0, 1'b1); step(1); chk();

        lose("loss1");
        qualify("relock1");

        // glitch in WAIT_LOCK: 10 high, 1 low, then high -> 11-edge delay
        lose("loss2");
        bus.locked_in = 1'b1; step(10);
        bus.locked_in = 1'b0;
        push("glitch", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();
        qualify("glitch");

        // drop in HOLD once hold_cnt reaches 30 (edge 47), seen at edge 48
        lose("loss3");
        bus.locked_in = 1'b1; step(46);
        bus.locked_in = 1'b0;
        push("hdrop_e47", S_HOLD, 1'b1, 1'b0); step(2); chk();
        push("hdrop_e48", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();
        qualify("hdrop");

        // drop seen exactly on the final hold edge still returns to WAIT_LOCK
        lose("loss4");
        bus.locked_in = 1'b1; step(79);
        bus.locked_in = 1'b0;
        push("fdrop_e80", S_HOLD, 1'b1, 1'b0); step(2); chk();
        push("fdrop_e81", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();

        for (int i = 0; i < 300; i++) begin
            qualify("rep");
            lose("rep");
        end

        qualify("final");
        rst_n = 1'b0;
        m_rc = 0;
        push("midrun_rst", S_RESET, 1'b1, 1'b0); step(1); chk();
        rst_n = 1'b1;
        push("post_rst", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();

`ifdef LOCK_TIMEOUT_EN
        bus.locked_in = 1'b0;
        push("to_99", S_WAIT_LOCK, 1'b1, 1'b0); step(99); chk();
        m_to = 1'b1;
        push("to_100", S_WAIT_LOCK, 1'b1, 1'b0); step(1); chk();
        step(3);
        qualify("to_lock");
        rst_n = 1'b0;
        m_to = 1'b0;
        push("to_clr", S_RESET, 1'b1, 1'b0); step(1); chk();
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
